// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - field-set input and instruction-memory write stream bundle
interface instruction_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [3:0]        in_func;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [3:0]        in_imm;
  logic              instr_valid;
  logic              instr_ready;
  logic [18:0]       instr_code;
  logic [ADDR_W-1:0] instr_addr;

  modport slave (
    input  in_valid, in_opcode, in_func, in_rd, in_rs1, in_rs2, in_imm, instr_ready,
    output in_ready, instr_valid, instr_code, instr_addr
  );

  modport master (
    output in_valid, in_opcode, in_func, in_rd, in_rs1, in_rs2, in_imm, instr_ready,
    input  in_ready, instr_valid, instr_code, instr_addr
  );
endinterface

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs instruction fields into 19-bit words, buffers and streams them with addresses
// Optional: ILLEGAL_DROP_EN drops illegal field sets instead of enqueuing a NOP word.
module instruction_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instruction_encoder_if.slave  bus,
  input  logic                  flush,
  input  logic                  load_base,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  err_pulse,
  output logic [7:0]            err_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [18:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              ready_en;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        fa, fb, fc;
  logic              legal;
  logic [18:0]       word;
  logic              full, empty, accept, push, pop;

  always_comb begin
    fa    = 4'd0;
    fb    = 4'd0;
    fc    = 4'd0;
    legal = 1'b1;
    case (bus.in_opcode)
      3'b001: begin
        fa = bus.in_rd;
        fb = bus.in_rs1;
        fc = bus.in_rs2;
      end
      3'b010: begin
        // func 0000/1111 make the decoder treat rs1 as the destination
        fa = (bus.in_func == 4'h0 || bus.in_func == 4'hF) ? bus.in_rs1 : bus.in_rd;
        fb = bus.in_rs1;
        fc = bus.in_imm;
      end
      3'b011: begin
        fa    = bus.in_imm;
        fb    = bus.in_rs1;
        legal = (bus.in_func[3:1] == 3'b000);
      end
      3'b100: begin
        fa    = bus.in_imm;
        fb    = bus.in_rs1;
        fc    = bus.in_rs2;
        legal = (bus.in_func[3:1] == 3'b000);
      end
      3'b101: fc = bus.in_imm;
      3'b110: begin
        fa = bus.in_imm;
        fb = bus.in_rs1;
      end
      3'b111: legal = 1'b0;
      default: ;
    endcase
    word = (bus.in_opcode == 3'b000 || !legal) ? 19'd0
                                               : {bus.in_func, fc, fb, fa, bus.in_opcode};
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign bus.in_ready = ready_en && !full && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
`ifdef ILLEGAL_DROP_EN
  assign push = accept && legal;
`else
  assign push = accept;
`endif
  assign pop = !empty && bus.instr_ready && !flush;

  assign bus.instr_valid = !empty;
  assign bus.instr_code  = empty ? 19'd0 : mem[rd_ptr[PTR_W-1:0]];
  assign bus.instr_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr_q    <= '0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // a load wins over the increment; the word popped this cycle used the old address
      if (load_base)  addr_q <= base_addr;
      else if (pop)   addr_q <= addr_q + 1'b1;
      err_pulse <= accept && !legal;
      if (accept && !legal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed vector bench for instruction_encoder
module tb_instruction_encoder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       load_base = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic       err_pulse;
  logic [7:0] err_count;

  instruction_encoder_if #(.ADDR_W(8)) bus ();

  instruction_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .flush     (flush),
    .load_base (load_base),
    .base_addr (base_addr),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  func, rd, rs1, rs2, imm;
    logic [18:0] code;
    logic        err;
  } vec_t;

  vec_t        tbl [12];
  logic [18:0] bp  [5];
  logic [18:0] exp_q[$];
  logic [18:0] pend_code;
  logic [7:0]  exp_addr;
  logic [7:0]  exp_errs;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input vec_t v);
    bus.in_opcode = v.op;
    bus.in_func   = v.func;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_imm    = v.imm;
  endtask

  task automatic set_r(input logic [3:0] rd);
    bus.in_opcode = 3'd1;
    bus.in_func   = 4'd0;
    bus.in_rd     = rd;
    bus.in_rs1    = 4'd0;
    bus.in_rs2    = 4'd0;
    bus.in_imm    = 4'd0;
  endtask

  // pops n words against the scoreboard; a held input is recorded when it is taken
  task automatic drain(input int n);
    int  got;
    logic acc;
    got = 0;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 50 && got < n; c++) begin
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'd1, 32'd0);
        end else begin
          chk("drain_code", bus.instr_code, exp_q[0]);
          chk("drain_addr", bus.instr_addr, exp_addr);
          void'(exp_q.pop_front());
        end
        exp_addr++;
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) exp_q.push_back(pend_code);
      tick();
      if (acc) bus.in_valid = 1'b0;
    end
    bus.instr_ready = 1'b0;
    chk("drain_count", got, n);
  endtask

  initial begin
    tbl[0]  = '{3'd1, 4'h0, 4'h3, 4'h1, 4'h2, 4'h0, 19'h01099, 1'b0};
    tbl[1]  = '{3'd2, 4'h0, 4'h9, 4'h5, 4'h0, 4'h7, 19'h03AAA, 1'b0};
    tbl[2]  = '{3'd2, 4'h3, 4'h9, 4'h5, 4'h0, 4'h7, 19'h1BACA, 1'b0};
    tbl[3]  = '{3'd2, 4'hF, 4'h9, 4'h5, 4'h0, 4'h7, 19'h7BAAA, 1'b0};
    tbl[4]  = '{3'd3, 4'h1, 4'h2, 4'h4, 4'h9, 4'h6, 19'h08233, 1'b0};
    tbl[5]  = '{3'd3, 4'h2, 4'h2, 4'h4, 4'h9, 4'h6, 19'h00000, 1'b1};
    tbl[6]  = '{3'd4, 4'h1, 4'h0, 4'h3, 4'hC, 4'hA, 19'h0E1D4, 1'b0};
    tbl[7]  = '{3'd4, 4'h2, 4'h0, 4'h3, 4'hC, 4'hA, 19'h00000, 1'b1};
    tbl[8]  = '{3'd5, 4'h9, 4'h7, 4'h3, 4'h2, 4'hF, 19'h4F805, 1'b0};
    tbl[9]  = '{3'd6, 4'hC, 4'h7, 4'hE, 4'h2, 4'h2, 19'h60716, 1'b0};
    tbl[10] = '{3'd0, 4'h5, 4'h7, 4'hE, 4'h2, 4'h2, 19'h00000, 1'b0};
    tbl[11] = '{3'd7, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 19'h00000, 1'b1};
    bp[0] = 19'h00009; bp[1] = 19'h00011; bp[2] = 19'h00019;
    bp[3] = 19'h00021; bp[4] = 19'h00029;

    bus.in_valid = 1'b0;
    bus.instr_ready = 1'b0;
    set_r(4'd0);

    #3;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_code", bus.instr_code, 0);
    chk("rst_addr", bus.instr_addr, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_low", bus.in_ready, 0);
    tick();
    chk("rel_in_ready_high", bus.in_ready, 1);

    // single-word encode vectors
    exp_addr = 8'd0;
    exp_errs = 8'd0;
    for (int i = 0; i < 12; i++) begin
      set_vec(tbl[i]);
      bus.in_valid = 1'b1;
      chk("vec_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      if (tbl[i].err) exp_errs++;
      chk("vec_err_pulse", err_pulse, tbl[i].err);
      chk("vec_err_count", err_count, exp_errs);
`ifdef ILLEGAL_DROP_EN
      if (tbl[i].err) begin
        chk("vec_drop_valid", bus.instr_valid, 0);
        chk("vec_drop_addr", bus.instr_addr, exp_addr);
        continue;
      end
`endif
      chk("vec_valid", bus.instr_valid, 1);
      chk("vec_code", bus.instr_code, tbl[i].code);
      chk("vec_addr", bus.instr_addr, exp_addr);
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      exp_addr++;
      chk("vec_popped", bus.instr_valid, 0);
      chk("vec_next_addr", bus.instr_addr, exp_addr);
      chk("vec_pulse_gone", err_pulse, 0);
    end

    // flush with a pop and a push attempt in the same cycle
    bus.in_valid = 1'b1;
    set_vec(tbl[0]);
    tick();
    set_vec(tbl[1]);
    tick();
    bus.in_valid = 1'b0;
    chk("fl_queued", bus.instr_valid, 1);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr_ready = 1'b1;
    set_vec(tbl[2]);
    #1;
    chk("fl_in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr_ready = 1'b0;
    chk("fl_valid", bus.instr_valid, 0);
    chk("fl_addr", bus.instr_addr, exp_addr);
    tick();
    chk("fl_still_empty", bus.instr_valid, 0);

    // asynchronous reset with words buffered
    bus.in_valid = 1'b1;
    set_vec(tbl[0]);
    tick();
    set_vec(tbl[1]);
    tick();
    bus.in_valid = 1'b0;
    chk("rs_queued", bus.instr_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_valid", bus.instr_valid, 0);
    chk("rs_code", bus.instr_code, 0);
    chk("rs_addr", bus.instr_addr, 0);
    chk("rs_err_count", err_count, 0);
    chk("rs_in_ready", bus.in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rs_rel_low", bus.in_ready, 0);
    tick();
    chk("rs_rel_high", bus.in_ready, 1);
    exp_addr = 8'd0;

    // backpressure: four fill the FIFO, the fifth is held until a pop
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_r(4'(i + 1));
      chk("bp_in_ready", bus.in_ready, 1);
      exp_q.push_back(bp[i]);
      tick();
    end
    set_r(4'd5);
    chk("bp_full", bus.in_ready, 0);
    tick();
    chk("bp_held", bus.in_ready, 0);
    pend_code = bp[4];
    drain(5);
    chk("bp_leftover", exp_q.size(), 0);

    // base load and wrap past all-ones
    load_base = 1'b1;
    base_addr = 8'hFE;
    tick();
    load_base = 1'b0;
    exp_addr = 8'hFE;
    chk("ld_addr", bus.instr_addr, 8'hFE);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_vec(tbl[i]);
      exp_q.push_back(tbl[i].code);
      tick();
    end
    bus.in_valid = 1'b0;
    drain(3);
    chk("wrap_addr", bus.instr_addr, 8'h01);

    // load coincident with a pop
    bus.in_valid = 1'b1;
    set_vec(tbl[3]);
    tick();
    set_vec(tbl[4]);
    tick();
    bus.in_valid = 1'b0;
    chk("lp_head_addr", bus.instr_addr, exp_addr);
    chk("lp_head_code", bus.instr_code, tbl[3].code);
    bus.instr_ready = 1'b1;
    load_base = 1'b1;
    base_addr = 8'h40;
    tick();
    load_base = 1'b0;
    bus.instr_ready = 1'b0;
    chk("lp_addr", bus.instr_addr, 8'h40);
    chk("lp_valid", bus.instr_valid, 1);
    chk("lp_code", bus.instr_code, tbl[4].code);
    exp_addr = 8'h40;
    exp_q.push_back(tbl[4].code);
    drain(1);
    chk("lp_final_addr", bus.instr_addr, 8'h41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Packs structured instruction fields (opcode, func, registers, immediate) into the 19-bit instruction word the decode stage consumes.
- Buffers encoded words in a small FIFO and streams them, with an auto-incrementing address, to the instruction-memory write port.
- Used by the program loader and the test harness to fill instruction memory.
- Flags illegal field combinations.

Parameters:
- ADDR_W, 8, instruction-memory address width; address counter wraps modulo 2^ADDR_W.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept; equals !full && !flush
- in_opcode  in  3  instruction class
- in_func  in  4  function code
- in_rd  in  4  destination register
- in_rs1  in  4  source register 1
- in_rs2  in  4  source register 2 (R, B)
- in_imm  in  4  immediate, memory address, branch offset or jump target
- flush  in  1  discard all buffered words
- load_base  in  1  load address counter
- base_addr  in  ADDR_W  value loaded by load_base
- instr_valid  out  1  FIFO head valid (!empty)
- instr_ready  in  1  memory accepts word
- instr_code  out  19  FIFO head word; 0 when empty
- instr_addr  out  ADDR_W  target address of head word
- err_pulse  out  1  one-cycle pulse, registered, on accepting an illegal field set
- err_count  out  8  illegal field sets accepted; saturates at 255

Behaviour:
- Word layout: [2:0] opcode, [6:3] A, [10:7] B, [14:11] C, [18:15] func.
- Packing is combinational from in_* and is written to the FIFO on the accept edge (in_valid && in_ready).
- 001 R: A=rd, B=rs1, C=rs2. Any func is legal.
- 010 I: B=rs1, C=imm, A=rd. Exception: if func is 0000 or 1111, A=rs1 (the decoder uses rs1 as destination for these).
- 011 S: A=imm, B=rs1, C=0. Only func 0000 (store) and 0001 (load) are legal.
- 100 B: A=imm, B=rs1, C=rs2. Only func 0000 (beq) and 0001 (bne) are legal.
- 101 J: A=0, B=0, C=imm. func is passed through.
- 110 X: A=imm, B=rs1, C=0. Any func is legal.
- 000 NOP: whole word is 0. Always legal.
- Opcode 111 is illegal.
- Latency: accept at edge N gives instr_valid=1 from cycle N+1 when the FIFO was empty. There is no in-to-out bypass.
- Output handshake: the word is popped and instr_addr increments when instr_valid && instr_ready. Increment wraps from all-ones to 0.
- instr_code and instr_addr must be held stable while instr_valid && !instr_ready.
- Full FIFO: in_ready=0 and the held input is not consumed. A pop while full raises in_ready on the next cycle.
- Push and pop in the same cycle at non-empty, non-full: occupancy is unchanged and order is preserved.
- flush: clears FIFO pointers on the next edge and forces in_ready=0 in that cycle, so no push. The address counter is unaffected. Any pop in that cycle is ignored.
- load_base:
  - Loads base_addr on the next edge.
  - Has priority over the increment from a simultaneous pop; the popped word still used the old address.
  - Does not affect the FIFO.
- err_pulse is asserted the cycle after an illegal accept. err_count increments on the same edge.
- Reset values (reset_n low, immediate and asynchronous):
  - FIFO empty, in_ready=0, instr_valid=0, instr_code=0, instr_addr=0, err_pulse=0, err_count=0.
  - in_ready rises on the first clk edge after reset_n deasserts.
  - Reset mid-transfer discards all buffered words.

Optional Feature:
- Macro: ILLEGAL_DROP_EN.
- Defined: an illegal field set is handshaken (in_ready honoured) but nothing is enqueued and the address does not advance. err_pulse and err_count update.
- Undefined: an illegal field set is replaced by the NOP word 19'h00000, enqueued, and given an address. err_pulse and err_count update identically.

Test Plan:
- R-type: opcode 001, func 0000, rd 3, rs1 1, rs2 2 after reset -> next cycle instr_valid=1, instr_code=19'h01099, instr_addr=0. After pop, instr_addr=1, err_count=0.
- I-type: opcode 010, func 0000, rd 9, rs1 5, imm 7 -> instr_code=19'h03AAA (A field = rs1 = 5, not rd).
- Illegal: opcode 100 with func 0010 -> err_pulse for 1 cycle, err_count=1. Without macro, instr_code=0 is emitted at the next address. With ILLEGAL_DROP_EN, instr_valid stays 0 and the address is unchanged.
- Backpressure: instr_ready=0, 5 back-to-back valid inputs -> in_ready=0 after 4th accept and the 5th is held. Raise instr_ready -> 5 words out in order at addresses 0 to 4, no loss or duplication.
- Wrap/load: load_base with base_addr=8'hFE, then 3 instructions -> instr_addr FE, FF, 00. load_base coincident with a pop -> next address equals base_addr.
- Reset/flush: 2 words queued, then flush -> instr_valid=0 next cycle, address kept. Repeat with reset_n low instead -> instr_valid=0, instr_addr=0, err_count=0 immediately, in_ready=1 one edge after release.
